// File: rtl/aaa_deser_pkg.sv
// Shared types and sizing helpers for the aaa_deser bit-serial deserializer.
// Frame length depends on the AAA_DESER_PARITY_EN build option (see aaa_deser.sv).
package aaa_deser_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int FIFO_DEPTH = 2;

    function automatic int frame_len(input int width, input bit par_en);
        return par_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/aaa_deser_fifo.sv
// Two-entry word FIFO; a pop in the same cycle as a push while full frees the slot.
// Data storage is left unreset; the output reads zero whenever the FIFO is empty.
module aaa_deser_fifo
    import aaa_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (do_pop && !do_push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/aaa_deser.sv
// LSB-first serial-to-word deserializer for the bar stage's aaa output, with a 2-word
// output buffer and sticky overflow. Optional trailing even-parity bit: AAA_DESER_PARITY_EN.
module aaa_deser
    import aaa_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             aaa,
    input  logic             aaa_vld,
    input  logic             aaa_sof,
    output logic [WIDTH-1:0] word,
    output logic             word_vld,
    input  logic             word_rdy,
    output logic             ovf,
    input  logic             clr_ovf,
    output logic             par_err
);

`ifdef AAA_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int FLEN  = frame_len(WIDTH, PAR_EN);
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FLEN - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // The final frame bit is never stored; it is taken straight from aaa at commit.
    logic [FLEN-2:0]  shreg_p0;
    logic [FLEN-1:0]  frame_c;
    logic             last_bit;
    logic             par_ok;
    logic             commit;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;

    assign frame_c  = {aaa, shreg_p0};
    assign last_bit = aaa_vld & ~aaa_sof & (state == COLLECT) & (cnt == LAST);
    assign commit   = last_bit & par_ok;
    assign word_vld = ~empty;
    assign pop      = word_vld & word_rdy;
    assign drop     = commit & full & ~pop;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (aaa_vld) begin
            if (aaa_sof) begin
                state <= COLLECT;
                cnt   <= CNT_W'(1);
            end else if (state == COLLECT) begin
                if (cnt == LAST) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Serial capture stage
    always_ff @(posedge clk) begin
        for (int i = 0; i < FLEN - 1; i++) begin
            if (aaa_vld && (aaa_sof ? (i == 0) : (state == COLLECT && cnt == CNT_W'(i))))
                shreg_p0[i] <= aaa;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

`ifdef AAA_DESER_PARITY_EN
    assign par_ok = ~^frame_c;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            par_err <= 1'b0;
        else
            par_err <= last_bit & ~par_ok;
    end
`else
    assign par_ok  = 1'b1;
    assign par_err = 1'b0;
`endif

    aaa_deser_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .push    (commit),
        .pop     (pop),
        .din     (frame_c[WIDTH-1:0]),
        .dout    (word),
        .full    (full),
        .empty   (empty)
    );

endmodule
